// File: rtl/osc_freq_meter_if.sv
// Control, result handshake and status bundle for osc_freq_meter.
// OSC_FREQ_MINMAX_EN adds the cnt_min/cnt_max statistics outputs.
interface osc_freq_meter_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             cont;
   logic             clear;
   logic             busy;
   logic [CNT_W-1:0] result;
   logic             result_valid;
   logic             result_ready;
   logic             saturated;
   logic             overrun;
`ifdef OSC_FREQ_MINMAX_EN
   logic [CNT_W-1:0] cnt_min;
   logic [CNT_W-1:0] cnt_max;

   modport master (
      output start, cont, clear, result_ready,
      input  busy, result, result_valid, saturated, overrun, cnt_min, cnt_max
   );
   modport slave (
      input  start, cont, clear, result_ready,
      output busy, result, result_valid, saturated, overrun, cnt_min, cnt_max
   );
`else
   modport master (
      output start, cont, clear, result_ready,
      input  busy, result, result_valid, saturated, overrun
   );
   modport slave (
      input  start, cont, clear, result_ready,
      output busy, result, result_valid, saturated, overrun
   );
`endif
endinterface

// File: rtl/osc_freq_meter.sv
// Counts synchronized rising edges of osc_in over a GATE_CYCLES window and holds the count
// behind a valid/ready handshake. Define OSC_FREQ_MINMAX_EN for running min/max of results.
module osc_freq_meter #(
   parameter int GATE_CYCLES = 1000,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            osc_in,
   osc_freq_meter_if.slave bus
);
   localparam int                GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 state_r;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   hist_r;
   logic [GATE_W-1:0]      gate_r;
   logic [CNT_W-1:0]       cnt_r;
   logic [CNT_W-1:0]       result_r;
   logic                   busy_r;
   logic                   valid_r;
   logic                   sat_r;
   logic                   ovr_r;

   logic                   edge_s;
   logic                   load_s;
   logic                   take_s;
   logic                   sat_hit_s;
   logic [CNT_W-1:0]       cnt_next_s;

   // Synchronizer chain on the asynchronous oscillator plus one history flop for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         hist_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], osc_in};
         hist_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Next count with ceiling clamp; an increment attempted at the ceiling flags saturation
   always_comb begin
      edge_s     = sync_r[SYNC_STAGES-1] & ~hist_r;
      load_s     = (state_r == COUNT) && (gate_r == {GATE_W{1'b0}});
      take_s     = valid_r & bus.result_ready;
      cnt_next_s = cnt_r;
      sat_hit_s  = 1'b0;
      if ((state_r == COUNT) && edge_s) begin
         if (cnt_r == CNT_MAX) begin
            sat_hit_s = 1'b1;
         end else begin
            cnt_next_s = cnt_r + CNT_ONE;
         end
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Measurement FSM: gate timer, edge counter and busy indication
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         gate_r  <= {GATE_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start | bus.cont) begin
                  state_r <= COUNT;
                  gate_r  <= GATE_LOAD;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            COUNT: begin
               cnt_r <= cnt_next_s;
               if (gate_r == {GATE_W{1'b0}}) begin
                  state_r <= DONE;
               end else begin
                  gate_r <= gate_r - GATE_ONE;
               end
            end
            DONE: begin
               // Edges seen during this cycle are dropped; the reload restarts from zero
               if (bus.cont) begin
                  state_r <= COUNT;
                  gate_r  <= GATE_LOAD;
                  cnt_r   <= {CNT_W{1'b0}};
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Result register and valid flag; a load wins over a same-cycle consume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_r <= {CNT_W{1'b0}};
         valid_r  <= 1'b0;
      end else if (load_s) begin
         result_r <= cnt_next_s;
         valid_r  <= 1'b1;
      end else if (take_s) begin
         valid_r  <= 1'b0;
      end
   end

   // Sticky status flags; clear outranks a set in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_r <= 1'b0;
         ovr_r <= 1'b0;
      end else if (bus.clear) begin
         sat_r <= 1'b0;
         ovr_r <= 1'b0;
      end else begin
         if (sat_hit_s) begin
            sat_r <= 1'b1;
         end
         if (load_s && valid_r && !bus.result_ready) begin
            ovr_r <= 1'b1;
         end
      end
   end

   assign bus.busy         = busy_r;
   assign bus.result       = result_r;
   assign bus.result_valid = valid_r;
   assign bus.saturated    = sat_r;
   assign bus.overrun      = ovr_r;

`ifdef OSC_FREQ_MINMAX_EN
   logic [CNT_W-1:0] min_r;
   logic [CNT_W-1:0] max_r;

   // Running extremes of loaded results since reset or the last clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_r <= CNT_MAX;
         max_r <= {CNT_W{1'b0}};
      end else if (bus.clear) begin
         min_r <= CNT_MAX;
         max_r <= {CNT_W{1'b0}};
      end else if (load_s) begin
         if (cnt_next_s < min_r) begin
            min_r <= cnt_next_s;
         end
         if (cnt_next_s > max_r) begin
            max_r <= cnt_next_s;
         end
      end
   end

   assign bus.cnt_min = min_r;
   assign bus.cnt_max = max_r;
`endif

endmodule
